// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO read-side drain engine.
// Holds the FSM encoding, default data width and counter widths.
package fifo_pkg;

    localparam int WIDTH_DEF  = 16;
    localparam int WORD_CNT_W = 32;
    localparam int ERR_CNT_W  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } fifo_state_t;

    // Error counter sticks at all-ones rather than wrapping.
    function automatic logic [ERR_CNT_W-1:0] sat_inc_err(input logic [ERR_CNT_W-1:0] v);
        return (&v) ? v : v + ERR_CNT_W'(1);
    endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry in-order skid buffer. Head entry drives the output data directly,
// so it only changes on a pop or when a push lands in an empty buffer.
module fifo_skid_buf
    import fifo_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [1:0]       o_occ,
    output logic [WIDTH-1:0] o_head
);

    logic [1:0]       r_occ;
    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_tail;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_occ  <= 2'd0;
            r_head <= '0;
            r_tail <= '0;
        end else begin
            case ({i_push, i_pop})
                2'b10: begin
                    if (r_occ == 2'd0) begin
                        r_head <= i_push_data;
                    end else begin
                        r_tail <= i_push_data;
                    end
                    r_occ <= r_occ + 2'd1;
                end
                2'b01: begin
                    r_head <= r_tail;
                    r_occ  <= r_occ - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged; the pushed word goes behind whatever remains.
                    if (r_occ == 2'd1) begin
                        r_head <= i_push_data;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= i_push_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_occ  = r_occ;
    assign o_head = r_head;

endmodule

// File: rtl/fifo_rd_drain.sv
// Drains a 1-cycle-latency FIFO read port into a valid/ready stream through a
// two-entry skid buffer, counting delivered words and discarded (errored) reads.
module fifo_rd_drain
    import fifo_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                  rd_clk_i,
    input  logic                  rst_i,
    input  logic                  enable_i,
    input  logic                  fifo_empty_i,
    input  logic [WIDTH-1:0]      fifo_rdata_i,
    input  logic                  fifo_rd_error_i,
    output logic                  fifo_rd_en_o,
    output logic [WIDTH-1:0]      m_data_o,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [WORD_CNT_W-1:0] word_cnt_o,
    output logic [ERR_CNT_W-1:0]  err_cnt_o,
    output logic                  busy_o,
    output fifo_state_t           state_o
);

    fifo_state_t           r_state;
    logic                  r_inflight;
    logic [WORD_CNT_W-1:0] r_word_cnt;
    logic [ERR_CNT_W-1:0]  r_err_cnt;

    logic [1:0] w_occ;
    logic       w_pop;
    logic       w_push;
    logic       w_discard;
    logic [2:0] w_level;

    // Stream handshake: a word transfers on every rising edge where m_valid_o
    // and m_ready_i are both high; m_data_o is held while valid waits for ready.
    assign m_valid_o = (w_occ != 2'd0);
    assign w_pop     = m_valid_o & m_ready_i;
    assign w_push    = r_inflight & ~fifo_rd_error_i;
    assign w_discard = r_inflight & fifo_rd_error_i;

    // Slots committed after this edge; a same-cycle pop frees one, which is
    // what lets m_ready_i reach the read strobe for back-to-back reads.
    assign w_level      = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign fifo_rd_en_o = (r_state == RUN) & ~fifo_empty_i & (w_level < 3'd2);

    always_ff @(posedge rd_clk_i) begin
        if (rst_i) begin
            r_state    <= IDLE;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= fifo_rd_en_o;
            case (r_state)
                IDLE: begin
                    if (enable_i) r_state <= RUN;
                end
                RUN: begin
                    if (!enable_i) r_state <= DRAIN;
                end
                DRAIN: begin
                    if (enable_i) begin
                        r_state <= RUN;
                    end else if (w_occ == 2'd0 && !r_inflight) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge rd_clk_i) begin
        if (rst_i) begin
            r_word_cnt <= '0;
            r_err_cnt  <= '0;
        end else begin
            if (w_pop) r_word_cnt <= r_word_cnt + WORD_CNT_W'(1);
            if (w_discard) r_err_cnt <= sat_inc_err(r_err_cnt);
        end
    end

    fifo_skid_buf #(
        .WIDTH(WIDTH)
    ) u_skid (
        .i_clk       (rd_clk_i),
        .i_rst       (rst_i),
        .i_push      (w_push),
        .i_push_data (fifo_rdata_i),
        .i_pop       (w_pop),
        .o_occ       (w_occ),
        .o_head      (m_data_o)
    );

    assign word_cnt_o = r_word_cnt;
    assign err_cnt_o  = r_err_cnt;
    assign busy_o     = (r_state != IDLE);
    assign state_o    = r_state;

endmodule

// File: tb/tb_fifo_rd_drain.sv
// Directed + randomized bench for fifo_rd_drain with a FIFO model and a
// queue-based expectation of the output stream.
module tb_fifo_rd_drain;
  import fifo_pkg::*;

  logic        rd_clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        enable_i = 1'b0;
  logic        fifo_empty_i = 1'b1;
  logic [15:0] fifo_rdata_i = 16'h0;
  logic        fifo_rd_error_i = 1'b0;
  logic        m_ready_i = 1'b0;
  logic        fifo_rd_en_o;
  logic [15:0] m_data_o;
  logic        m_valid_o;
  logic [31:0] word_cnt_o;
  logic [15:0] err_cnt_o;
  logic        busy_o;
  fifo_state_t state_o;

  fifo_rd_drain #(.WIDTH(16)) dut (
    .rd_clk_i        (rd_clk_i),
    .rst_i           (rst_i),
    .enable_i        (enable_i),
    .fifo_empty_i    (fifo_empty_i),
    .fifo_rdata_i    (fifo_rdata_i),
    .fifo_rd_error_i (fifo_rd_error_i),
    .fifo_rd_en_o    (fifo_rd_en_o),
    .m_data_o        (m_data_o),
    .m_valid_o       (m_valid_o),
    .m_ready_i       (m_ready_i),
    .word_cnt_o      (word_cnt_o),
    .err_cnt_o       (err_cnt_o),
    .busy_o          (busy_o),
    .state_o         (state_o)
  );

  // clock / watchdog
  always #5 rd_clk_i = ~rd_clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  int n_cmp = 0;
  int n_err = 0;

  // FIFO contents, words expected on the stream, words actually seen
  logic [15:0] fifo_q[$];
  logic [15:0] exp_q[$];
  logic [15:0] out_log[$];
  int          pop_cyc[$];

  logic        pend_valid = 1'b0;
  logic [15:0] pend_data = 16'h0;
  fifo_state_t mst = IDLE;
  logic [31:0] m_wcnt = 32'h0;
  logic [15:0] m_ecnt = 16'h0;
  logic        force_empty = 1'b0;
  logic        err_en = 1'b0;
  logic        rand_err = 1'b0;
  logic [15:0] err_word = 16'h0;
  int          cyc = 0;

  logic        s_rd, s_valid;
  logic [15:0] s_data;
  fifo_state_t s_state;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int first, input int n);
    fifo_q.delete();
    for (int i = 0; i < n; i++) fifo_q.push_back(16'(first + i));
  endtask

  // One clock cycle: drive FIFO side at negedge, check, advance model, cross posedge.
  task automatic tick();
    logic exp_valid, exp_pop, exp_rd, idle_ok;
    int   lvl;
    @(negedge rd_clk_i);
    cyc++;
    fifo_empty_i = force_empty || (fifo_q.size() == 0);
    if (pend_valid) begin
      fifo_rdata_i    = pend_data;
      fifo_rd_error_i = rand_err ? ($urandom_range(0, 5) == 0) : (err_en && pend_data == err_word);
    end else begin
      fifo_rdata_i    = 16'($urandom);
      fifo_rd_error_i = 1'($urandom_range(0, 1));
    end
    #1;
    exp_valid = (exp_q.size() != 0);
    exp_pop   = exp_valid && m_ready_i;
    lvl       = exp_q.size() + int'(pend_valid) - int'(exp_pop);
    exp_rd    = (mst == RUN) && !fifo_empty_i && (lvl < 2);
    s_rd = fifo_rd_en_o; s_valid = m_valid_o; s_data = m_data_o; s_state = state_o;
    chk("rd_en", 32'(fifo_rd_en_o), 32'(exp_rd));
    chk("m_valid", 32'(m_valid_o), 32'(exp_valid));
    if (exp_valid) chk("m_data", 32'(m_data_o), 32'(exp_q[0]));
    chk("state", 32'(state_o), 32'(mst));
    chk("busy", 32'(busy_o), 32'(mst != IDLE));
    chk("word_cnt", word_cnt_o, m_wcnt);
    chk("err_cnt", 32'(err_cnt_o), 32'(m_ecnt));
    if (m_valid_o && m_ready_i) begin
      out_log.push_back(m_data_o);
      pop_cyc.push_back(cyc);
    end
    idle_ok = (exp_q.size() == 0) && !pend_valid;
    if (exp_pop) begin
      void'(exp_q.pop_front());
      m_wcnt++;
    end
    if (pend_valid) begin
      if (fifo_rd_error_i) begin
        if (m_ecnt != 16'hFFFF) m_ecnt++;
      end else begin
        exp_q.push_back(pend_data);
      end
    end
    pend_valid = fifo_rd_en_o;
    if (fifo_rd_en_o) pend_data = (fifo_q.size() != 0) ? fifo_q.pop_front() : 16'hDEAD;
    case (mst)
      IDLE:    if (enable_i) mst = RUN;
      RUN:     if (!enable_i) mst = DRAIN;
      DRAIN:   if (enable_i) mst = RUN; else if (idle_ok) mst = IDLE;
      default: mst = IDLE;
    endcase
    @(posedge rd_clk_i);
    #1;
  endtask

  task automatic do_reset();
    @(negedge rd_clk_i);
    rst_i = 1'b1; enable_i = 1'b0; m_ready_i = 1'b0;
    @(negedge rd_clk_i);
    #1;
    chk("rst_rd_en", 32'(fifo_rd_en_o), 32'd0);
    chk("rst_valid", 32'(m_valid_o), 32'd0);
    chk("rst_data", 32'(m_data_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_wcnt", word_cnt_o, 32'd0);
    chk("rst_ecnt", 32'(err_cnt_o), 32'd0);
    chk("rst_state", 32'(state_o), 32'(IDLE));
    exp_q.delete(); out_log.delete(); pop_cyc.delete();
    pend_valid = 1'b0; mst = IDLE; m_wcnt = 32'h0; m_ecnt = 16'h0; cyc = 0;
    rst_i = 1'b0;
    @(posedge rd_clk_i);
    #1;
  endtask

  initial begin
    int n0, rd_cnt, v_cnt, k;
    logic [15:0] hold;
    repeat (2) @(posedge rd_clk_i);
    do_reset();

    // streaming 1..8 with ready held high
    load(1, 8); enable_i = 1'b1; m_ready_i = 1'b1;
    repeat (14) tick();
    chk("stream_count", 32'(out_log.size()), 32'd8);
    for (int i = 0; i < 8; i++) if (i < out_log.size()) chk("stream_order", 32'(out_log[i]), 32'(i + 1));
    if (pop_cyc.size() >= 8) chk("stream_rate", 32'(pop_cyc[7] - pop_cyc[0]), 32'd7);
    chk("stream_wcnt", word_cnt_o, 32'd8);
    enable_i = 1'b0;
    repeat (3) tick();
    chk("stream_busy_off", 32'(busy_o), 32'd0);

    // backpressure: buffer fills, reads stop, head stays put
    do_reset();
    load(16'h10, 8); enable_i = 1'b1; m_ready_i = 1'b0;
    repeat (5) tick();
    chk("bp_valid", 32'(s_valid), 32'd1);
    chk("bp_rd_off", 32'(s_rd), 32'd0);
    chk("bp_head", 32'(s_data), 32'h10);
    hold = s_data;
    repeat (3) begin
      tick();
      chk("bp_stable", 32'(s_data), 32'(hold));
      chk("bp_no_read", 32'(s_rd), 32'd0);
    end
    m_ready_i = 1'b1;
    repeat (14) tick();
    chk("bp_count", 32'(out_log.size()), 32'd8);
    for (int i = 0; i < 8; i++) if (i < out_log.size()) chk("bp_order", 32'(out_log[i]), 32'(16'h10 + i));

    // read error on the return of word 3
    do_reset();
    load(1, 4); err_en = 1'b1; err_word = 16'h3; enable_i = 1'b1; m_ready_i = 1'b1;
    repeat (10) tick();
    err_en = 1'b0;
    chk("err_count_out", 32'(out_log.size()), 32'd3);
    if (out_log.size() == 3) begin
      chk("err_w0", 32'(out_log[0]), 32'h1);
      chk("err_w1", 32'(out_log[1]), 32'h2);
      chk("err_w2", 32'(out_log[2]), 32'h4);
    end
    chk("err_cnt_one", 32'(err_cnt_o), 32'd1);

    // drain: enter DRAIN with one word buffered and one in flight
    do_reset();
    load(1, 8); enable_i = 1'b1; m_ready_i = 1'b1;
    repeat (4) tick();
    enable_i = 1'b0;
    tick();
    n0 = out_log.size();
    tick();
    chk("drain_state", 32'(s_state), 32'(DRAIN));
    chk("drain_valid", 32'(s_valid), 32'd1);
    rd_cnt = int'(s_rd);
    k = 0;
    while (s_state != IDLE && k < 10) begin
      tick();
      rd_cnt += int'(s_rd);
      k++;
    end
    chk("drain_idle", 32'(s_state), 32'(IDLE));
    chk("drain_no_read", 32'(rd_cnt), 32'd0);
    chk("drain_words", 32'(out_log.size() - n0), 32'd2);

    // empty flag held: never read
    do_reset();
    load(16'h40, 4); force_empty = 1'b1; enable_i = 1'b1;
    rd_cnt = 0; v_cnt = 0;
    repeat (20) begin
      m_ready_i = 1'($urandom_range(0, 1));
      tick();
      rd_cnt += int'(s_rd);
      v_cnt += int'(s_valid);
    end
    chk("empty_rd", 32'(rd_cnt), 32'd0);
    chk("empty_valid", 32'(v_cnt), 32'd0);
    force_empty = 1'b0;

    // reset mid-stream with the buffer full
    do_reset();
    load(16'h20, 8); enable_i = 1'b1; m_ready_i = 1'b0;
    repeat (5) tick();
    chk("rstmid_full", 32'(s_valid), 32'd1);
    do_reset();
    m_ready_i = 1'b1;
    repeat (2) tick();
    chk("rstmid_nothing", 32'(out_log.size()), 32'd0);

    // word counter wrap
    @(negedge rd_clk_i);
    force dut.r_word_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.r_word_cnt;
    m_wcnt = 32'hFFFF_FFFF;
    tick();
    load(16'h55, 1); enable_i = 1'b1; m_ready_i = 1'b1;
    repeat (6) tick();
    chk("wrap_words", 32'(out_log.size()), 32'd1);
    chk("wrap_wcnt", word_cnt_o, 32'd0);
    enable_i = 1'b0;
    repeat (3) tick();

    // randomized enable / ready / read errors
    do_reset();
    fifo_q.delete();
    for (int i = 0; i < 60; i++) fifo_q.push_back(16'($urandom));
    rand_err = 1'b1;
    repeat (300) begin
      enable_i  = ($urandom_range(0, 9) != 0);
      m_ready_i = ($urandom_range(0, 2) != 0);
      tick();
    end
    enable_i = 1'b1; m_ready_i = 1'b1;
    k = 0;
    while ((fifo_q.size() != 0 || exp_q.size() != 0 || pend_valid) && k < 200) begin
      tick();
      k++;
    end
    enable_i = 1'b0;
    repeat (4) tick();
    rand_err = 1'b0;
    chk("rand_idle", 32'(busy_o), 32'd0);
    chk("rand_wcnt", word_cnt_o, 32'(out_log.size()));
    chk("rand_conserve", 32'(out_log.size()) + 32'(err_cnt_o), 32'd60);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_rd_drain.md
FIFO_RD_DRAIN -- requirements
Module: fifo_rd_drain

Interface
REQ-001 Parameter WIDTH, default 16: data width in bits; SHALL match the FIFO data width.
REQ-002 rd_clk_i  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst_i  in  1  reset, synchronous and active-high.
REQ-004 enable_i  in  1  high = drain the FIFO; low = stop issuing reads.
REQ-005 fifo_empty_i  in  1  FIFO read-side empty flag.
REQ-006 fifo_rdata_i  in  WIDTH  FIFO read data, valid one cycle after a read is issued.
REQ-007 fifo_rd_error_i  in  1  FIFO read error, sampled in the same cycle as the return data.
REQ-008 fifo_rd_en_o  out  1  read strobe to the FIFO.
REQ-009 m_data_o  out  WIDTH  output stream data.
REQ-010 m_valid_o  out  1  output stream valid.
REQ-011 m_ready_i  in  1  output stream ready.
REQ-012 word_cnt_o  out  32  count of words accepted on the output stream.
REQ-013 err_cnt_o  out  16  count of discarded reads.
REQ-014 busy_o  out  1  high in RUN or DRAIN.

Function
REQ-015 Read latency SHALL be 1: a read issued in cycle N returns data in cycle N+1.
REQ-016 Returned data SHALL be pushed into a 2-entry skid buffer; occ SHALL be the buffer occupancy (0..2); inflight SHALL be 1 in the cycle after a read was issued.
REQ-017 pop SHALL equal m_valid_o AND m_ready_i.
REQ-018 fifo_rd_en_o SHALL be state==RUN AND NOT fifo_empty_i AND (occ + inflight - pop) < 2.
REQ-019 The combinational path from m_ready_i to fifo_rd_en_o SHALL exist; this allows full throughput.
REQ-020 m_valid_o SHALL equal (occ != 0).
REQ-021 m_data_o SHALL show the oldest buffered word and SHALL hold stable while m_valid_o=1 and m_ready_i=0.
REQ-022 If fifo_rd_error_i=1 in a return cycle, the returned word SHALL be discarded.
REQ-023 A discarded word SHALL make err_cnt_o increment, saturating at 16'hFFFF.
REQ-024 word_cnt_o SHALL increment on each pop and wrap modulo 2^32.
REQ-025 A push and a pop in the same cycle SHALL leave occ unchanged and preserve FIFO order.
REQ-026 The buffer SHALL never overflow; REQ-018 guarantees occ+inflight <= 2.
REQ-027 FSM states and transitions:
  - IDLE -> RUN when enable_i=1.
  - RUN -> DRAIN when enable_i=0.
  - DRAIN -> RUN when enable_i=1.
  - DRAIN -> IDLE when occ==0 AND inflight==0.
REQ-028 In DRAIN, no new reads SHALL be issued; in-flight data SHALL still be accepted; buffered data SHALL still be presented.
REQ-029 When fifo_empty_i=1, no read SHALL be issued, regardless of state.

Reset
REQ-030 While rst_i=1 on a clock edge the block SHALL reset:
  - state=IDLE, occ=0, inflight=0
  - word_cnt_o=0, err_cnt_o=0
  - fifo_rd_en_o=0, m_valid_o=0, busy_o=0, m_data_o=0
REQ-031 A reset during RUN or DRAIN SHALL drop buffered and in-flight data without counting it.

Structure
REQ-032 A shared package fifo_pkg SHALL hold:
  - the WIDTH default (16)
  - the FSM state enum (IDLE, RUN, DRAIN)
  - counter width constants (32, 16)
REQ-033 The 2-entry buffer SHALL be a sub-module, fifo_skid_buf.

Verification
REQ-034 Streaming: FIFO preloaded with 0x0001..0x0008, enable_i=1, m_ready_i=1 -> 8 words out in order, one per cycle after the first; word_cnt_o=8; busy_o returns to 0 after disabling.
REQ-035 Backpressure: m_ready_i=0 for 5 cycles with data available -> occ=2; fifo_rd_en_o=0; m_data_o stable; no word lost or duplicated after release.
REQ-036 Read error: fifo_rd_error_i=1 on the return of word 0x0003 -> output is 0x0001, 0x0002, 0x0004; err_cnt_o=1.
REQ-037 Drain: enable_i dropped with occ=1 and inflight=1 -> no new read; 2 words delivered; state goes DRAIN then IDLE.
REQ-038 Empty: fifo_empty_i=1 throughout -> fifo_rd_en_o never asserts; m_valid_o=0.
REQ-039 Reset and wrap: rst_i asserted mid-stream with occ=2 -> all outputs at reset values next cycle. Separately, word_cnt forced to 32'hFFFFFFFF plus one pop -> word_cnt_o=0.
